// File: rtl/jesd204b_rst_seq.sv
// ---------------------------------------------------------------------------
// JesD204B link reset sequencer
//
// Purpose:
//   Combines a set of asynchronous per-source ready/enable signals into a
//   single ready indication. That indication passes through a synchroniser
//   that is cleared asynchronously. The link reset (reset_b) is then released
//   a programmable number of link_clk cycles after ready has been stable.
//   Losing ready, or a software re-sequence request, puts the link back into
//   reset.
//
// Ports:
//   link_clk     sole clock; all state changes on the rising edge
//   rst          asynchronous active-high reset
//   en           per-source ready/enable (asynchronous to link_clk)
//   en_mask      1 = source participates (quasi-static)
//   hold_cycles  release delay, latched when the wait phase starts
//   sw_reset     single-cycle synchronous request to re-run the sequence
//   reset_b      active-low link reset, registered, high only in RUN
//   busy         high while the hold count is running (WAIT)
//   state        IDLE=0, WAIT=1, RUN=2
//   drop_cnt     saturating count of ready losses while in RUN
//
// Configuration:
//   JESD_RST_DROP_CNT_EN  defined   -> drop_cnt counter is built
//                         undefined -> drop_cnt is tied to zero
// ---------------------------------------------------------------------------
module jesd204b_rst_seq #(
  parameter int N_EN        = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_W      = 8
) (
  input  logic              link_clk,
  input  logic              rst,
  input  logic [N_EN-1:0]   en,
  input  logic [N_EN-1:0]   en_mask,
  input  logic [CNT_W-1:0]  hold_cycles,
  input  logic              sw_reset,
  output logic              reset_b,
  output logic              busy,
  output logic [1:0]        state,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               ready;
  logic               ready_s;
  logic               sync_clr;

  // An all-zero mask means no source is participating, so there is nothing to
  // become ready. Otherwise every participating source must be enabled.
  assign ready    = (|en_mask) & (&(en | ~en_mask));

  // Losing ready clears the synchroniser without waiting for a clock edge.
  // This way the FSM sees the loss on the very next edge.
  assign sync_clr = rst | ~ready;

  // Synchroniser: a one walks through the chain only while ready stays high.
  always_ff @(posedge link_clk or posedge sync_clr) begin
    if (sync_clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ready_s = sync_q[SYNC_STAGES-1];

  // Next-state logic. The hold value is latched when WAIT is entered, so any
  // later change to hold_cycles cannot disturb a count already in progress.
  // The counter stops at equality, so it never wraps, even at the max hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ready_s) begin
          state_d = ST_WAIT;
          hold_d  = hold_cycles;
        end
      end
      ST_WAIT: begin
        if (!ready_s || sw_reset) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == hold_q) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!ready_s || sw_reset) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register. reset_b is registered from the next state.
  // This makes it rise on the same edge that RUN is entered, and fall on the
  // same edge that RUN is left.
  always_ff @(posedge link_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      reset_b <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      reset_b <= (state_d == ST_RUN);
    end
  end

  assign busy  = (state_q == ST_WAIT);
  assign state = state_q;

`ifdef JESD_RST_DROP_CNT_EN
  logic              drop_ev;
  logic [DROP_W-1:0] drop_q;

  // Only a ready loss in RUN counts. When a loss and sw_reset arrive
  // together, the event still counts exactly once.
  assign drop_ev = (state_q == ST_RUN) && !ready_s;

  // Saturating drop counter.
  always_ff @(posedge link_clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop_ev && (drop_q != {DROP_W{1'b1}})) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule
